dm_access_ctrl: RTL and testbench

//   M-stage data-memory access controller: sits between the M pipeline stage and a

---
 rtl/dm_access_ctrl_if.sv | 20 ++
 rtl/dm_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_dm_access_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_if.sv
// Data-memory request/ack bus between the M-stage access controller and memory.
interface dm_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// M-stage data-memory access controller: lane steering, pipeline stall,
// raw read capture, misalignment and timeout detection.
module dm_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    input  logic             m_re,
    input  logic             m_we,
    input  logic [31:0]      m_addr,
    input  logic [1:0]       m_len,
    input  logic [31:0]      m_wdata,
    output logic             m_stall,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    output logic             addr_err,
    output logic             bus_err,
    dm_access_ctrl_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic             is_load;

    logic             access;
    logic             misal;
    logic [3:0]       be_d;
    logic [31:0]      wd_d;
    logic             accept;
    logic             timeout;
    logic             stall_raw;
    logic             err_raw;

    assign access = m_valid & (m_re | m_we) & (m_len != 2'b11);

    always_comb begin
        misal = 1'b0;
        be_d  = 4'b0000;
        wd_d  = 32'h0;
        unique case (m_len)
            2'b00: begin
                misal = |m_addr[1:0];
                be_d  = 4'b1111;
                wd_d  = m_wdata;
            end
            2'b01: begin
                misal = m_addr[0];
                be_d  = m_addr[1] ? 4'b1100 : 4'b0011;
                wd_d  = m_addr[1] ? {m_wdata[15:0], 16'h0}
                                  : {16'h0, m_wdata[15:0]};
            end
            2'b10: begin
                be_d = 4'b0001 << m_addr[1:0];
                wd_d = {24'h0, m_wdata[7:0]} << {m_addr[1:0], 3'b000};
            end
            default: begin
                misal = 1'b0;
            end
        endcase
    end

    // A late ack is the only way out of REQ besides the timeout.
    assign timeout = (cnt == CNT_LAST) & ~mem.mem_ack;

    always_comb begin
        state_d   = state;
        stall_raw = 1'b0;
        err_raw   = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (access) begin
                    if (misal) begin
                        err_raw = 1'b1;
                    end else begin
                        stall_raw = 1'b1;
                        accept    = 1'b1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                stall_raw = 1'b1;
                if (mem.mem_ack || timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    assign m_stall  = stall_raw & ~reset;
    assign addr_err = err_raw & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            is_load        <= 1'b0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= 32'h0;
            mem.mem_byteen <= 4'b0000;
            mem.mem_wdata  <= 32'h0;
            rdata          <= 32'h0;
            rdata_valid    <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            state       <= state_d;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            if (accept) begin
                cnt            <= '0;
                is_load        <= ~m_we;
                mem.mem_req    <= 1'b1;
                mem.mem_we     <= m_we;
                mem.mem_addr   <= {m_addr[31:2], 2'b00};
                mem.mem_byteen <= be_d;
                mem.mem_wdata  <= wd_d;
            end
            if (state == REQ) begin
                if (mem.mem_ack) begin
                    mem.mem_req <= 1'b0;
                    if (is_load) begin
                        rdata       <= mem.mem_rdata;
                        rdata_valid <= 1'b1;
                    end
                end else if (timeout) begin
                    mem.mem_req <= 1'b0;
                    bus_err     <= 1'b1;
                    if (is_load) begin
                        rdata       <= 32'h0;
                        rdata_valid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: table of single accesses plus
// back-to-back and asynchronous reset sequences.
module tb_dm_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_re, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_len;
    logic        m_stall, rdata_valid, addr_err, bus_err;
    logic [31:0] rdata;

    dm_access_ctrl_if mem_bus ();

    dm_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_re       (m_re),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_len      (m_len),
        .m_wdata    (m_wdata),
        .m_stall    (m_stall),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .addr_err   (addr_err),
        .bus_err    (bus_err),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        re;
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_n;
        logic [31:0] rd;
        logic        exp_err;
        logic        exp_acc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic        exp_bus;
        int          exp_stalls;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stalls;
        m_valid = v.valid;
        m_re    = v.re;
        m_we    = v.we;
        m_len   = v.len;
        m_addr  = v.addr;
        m_wdata = v.wdata;
        #1;
        chk($sformatf("v%0d addr_err", idx), 32'(addr_err), 32'(v.exp_err));
        chk($sformatf("v%0d stall0", idx), 32'(m_stall), 32'(v.exp_acc));
        stalls = int'(m_stall);
        step();
        if (v.exp_acc) begin
            chk($sformatf("v%0d mem_req", idx), 32'(mem_bus.mem_req), 32'd1);
            chk($sformatf("v%0d mem_addr", idx), mem_bus.mem_addr,
                {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d byteen", idx), 32'(mem_bus.mem_byteen),
                32'(v.exp_be));
            chk($sformatf("v%0d mem_we", idx), 32'(mem_bus.mem_we), 32'(v.we));
            if (v.we) chk($sformatf("v%0d mem_wdata", idx),
                          mem_bus.mem_wdata, v.exp_wd);
            for (int k = 1; k <= 16; k++) begin
                stalls += int'(m_stall);
                if (k == v.ack_n) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = v.rd;
                end
                step();
                mem_bus.mem_ack = 1'b0;
                if (!m_stall) break;
            end
            chk($sformatf("v%0d stall_cycles", idx), 32'(stalls),
                32'(v.exp_stalls));
            chk($sformatf("v%0d req_drop", idx), 32'(mem_bus.mem_req), 32'd0);
            chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(v.exp_bus));
            if (!v.exp_bus) chk($sformatf("v%0d rdata_valid", idx),
                                32'(rdata_valid), 32'(!v.we));
            chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
            m_valid = 1'b0;
            step();
            chk($sformatf("v%0d pulse_end", idx),
                32'({rdata_valid, bus_err, mem_bus.mem_req}), 32'd0);
        end else begin
            chk($sformatf("v%0d no_req", idx), 32'(mem_bus.mem_req), 32'd0);
            chk($sformatf("v%0d no_stall", idx), 32'(m_stall), 32'd0);
            chk($sformatf("v%0d rdata_hold", idx), rdata, v.exp_rdata);
            m_valid = 1'b0;
            step();
        end
    endtask

    initial begin
        // valid re we len addr wdata ack rd | err acc be wd bus stalls rdata
        vecs.push_back('{1,1,0,2'b00,32'h2000,32'h0,3,32'hDEADBEEF,
                         0,1,4'hF,32'h0,0,4,32'hDEADBEEF});
        vecs.push_back('{1,0,1,2'b10,32'h1003,32'hAB,1,32'h0,
                         0,1,4'h8,32'hAB000000,0,2,32'hDEADBEEF});
        vecs.push_back('{1,1,0,2'b01,32'h2001,32'h0,0,32'h0,
                         1,0,4'h0,32'h0,0,0,32'hDEADBEEF});
        vecs.push_back('{1,0,1,2'b01,32'h2,32'h12,1,32'h0,
                         0,1,4'hC,32'h00120000,0,2,32'hDEADBEEF});
        vecs.push_back('{1,1,0,2'b10,32'h3,32'h0,2,32'h11223344,
                         0,1,4'h8,32'h0,0,3,32'h11223344});
        vecs.push_back('{1,0,1,2'b00,32'h4000,32'hCAFEBABE,2,32'h0,
                         0,1,4'hF,32'hCAFEBABE,0,3,32'h11223344});
        vecs.push_back('{1,0,1,2'b01,32'h10,32'hFFFF5678,1,32'h0,
                         0,1,4'h3,32'h00005678,0,2,32'h11223344});
        vecs.push_back('{1,1,0,2'b10,32'h11,32'h0,1,32'h0000AA00,
                         0,1,4'h2,32'h0,0,2,32'h0000AA00});
        vecs.push_back('{1,0,1,2'b10,32'h22,32'h123456C3,3,32'h0,
                         0,1,4'h4,32'h00C30000,0,4,32'h0000AA00});
        vecs.push_back('{1,1,0,2'b11,32'h30,32'h0,0,32'h0,
                         0,0,4'h0,32'h0,0,0,32'h0000AA00});
        vecs.push_back('{1,1,0,2'b00,32'h2002,32'h0,0,32'h0,
                         1,0,4'h0,32'h0,0,0,32'h0000AA00});
        vecs.push_back('{0,1,0,2'b00,32'h40,32'h0,0,32'h0,
                         0,0,4'h0,32'h0,0,0,32'h0000AA00});
        vecs.push_back('{1,1,1,2'b10,32'h101,32'h5A,1,32'hFFFFFFFF,
                         0,1,4'h2,32'h00005A00,0,2,32'h0000AA00});
        vecs.push_back('{1,1,0,2'b00,32'h50,32'h0,0,32'h0,
                         0,1,4'hF,32'h0,1,TO+1,32'h0});
        vecs.push_back('{1,1,0,2'b00,32'h60,32'h0,1,32'h87654321,
                         0,1,4'hF,32'h0,0,2,32'h87654321});

        reset = 1'b1;
        m_valid = 1'b0; m_re = 1'b0; m_we = 1'b0;
        m_len = 2'b00; m_addr = 32'h0; m_wdata = 32'h0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        step();
        chk("reset_outs", 32'({m_stall, rdata_valid, addr_err, bus_err,
                               mem_bus.mem_req, mem_bus.mem_we,
                               mem_bus.mem_byteen}), 32'd0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_addr", mem_bus.mem_addr, 32'h0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // sh then lb with the lb presented as soon as the sh retires
        m_valid = 1'b1; m_re = 1'b0; m_we = 1'b1;
        m_len = 2'b01; m_addr = 32'h2; m_wdata = 32'h12;
        step();
        chk("b2b sh_be", 32'(mem_bus.mem_byteen), 32'hC);
        chk("b2b sh_wd", mem_bus.mem_wdata, 32'h00120000);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        m_re = 1'b1; m_we = 1'b0; m_len = 2'b10; m_addr = 32'h3;
        mem_bus.mem_rdata = 32'h00000055;
        #1;
        chk("b2b done_stall", 32'(m_stall), 32'd0);
        chk("b2b done_req", 32'(mem_bus.mem_req), 32'd0);
        step();
        chk("b2b idle_stall", 32'(m_stall), 32'd1);
        chk("b2b idle_req", 32'(mem_bus.mem_req), 32'd0);
        step();
        chk("b2b lb_req", 32'(mem_bus.mem_req), 32'd1);
        chk("b2b lb_be", 32'(mem_bus.mem_byteen), 32'h8);
        chk("b2b lb_we", 32'(mem_bus.mem_we), 32'd0);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("b2b lb_rdata", rdata, 32'h00000055);
        m_valid = 1'b0;
        step();

        // asynchronous reset in the middle of a request
        m_valid = 1'b1; m_re = 1'b1; m_we = 1'b0;
        m_len = 2'b00; m_addr = 32'h80;
        step();
        chk("rst req_up", 32'(mem_bus.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst req_async", 32'(mem_bus.mem_req), 32'd0);
        chk("rst stall_async", 32'(m_stall), 32'd0);
        step();
        reset = 1'b0;
        m_valid = 1'b0;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hFFFFFFFF;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("rst late_ack", 32'({rdata_valid, bus_err, mem_bus.mem_req}),
            32'd0);
        chk("rst rdata", rdata, 32'h0);

        // recovery: a fresh load goes through normally
        m_valid = 1'b1; m_addr = 32'h90;
        #1;
        chk("rec stall", 32'(m_stall), 32'd1);
        step();
        chk("rec req", 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'h0BADF00D;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("rec rdata", rdata, 32'h0BADF00D);
        chk("rec valid", 32'(rdata_valid), 32'd1);
        m_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
